// File: rtl/uart_pkg.sv
// Shared constants and the receiver state type for the UART.
package uart_pkg;
  localparam int OVERSAMPLE   = 8;  // sample ticks per bit
  localparam int DATA_BITS    = 8;
  localparam int START_SAMPLE = 4;  // ticks from start edge to mid start bit
  localparam int FRAME_BITS   = DATA_BITS + 2;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
endpackage

// File: rtl/uart_baud.sv
// Baud timing for the UART.
// Ports:
//   clk, reset  - system clock, async active-high reset
//   samp_clk    - one-clk oversample tick (accumulator carry)
//   tx_bit_clk  - one-clk tick every OVERSAMPLE samp_clk ticks (free running)
module uart_baud
  import uart_pkg::*;
#(
  parameter int Width = 16,
  parameter int Incr  = 1208
) (
  input  logic clk,
  input  logic reset,
  output logic samp_clk,
  output logic tx_bit_clk
);
  localparam int DW = $clog2(OVERSAMPLE);

  logic [Width-1:0] acc_q, acc_d;
  logic             samp_q, samp_d;
  logic [DW-1:0]    div_q, div_d;
  logic [Width:0]   sum;

  always_comb begin
    sum    = {1'b0, acc_q} + (Width+1)'(Incr);
    acc_d  = sum[Width-1:0];
    samp_d = sum[Width];
    div_d  = samp_q ? div_q + DW'(1) : div_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q  <= '0;
      samp_q <= 1'b0;
      div_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      samp_q <= samp_d;
      div_q  <= div_d;
    end
  end

  assign samp_clk   = samp_q;
  assign tx_bit_clk = samp_q && (div_q == DW'(OVERSAMPLE-1));
endmodule

// File: rtl/uart.sv
// 8N1 UART: transmitter, receiver with 8x oversampling.
// Ports:
//   clk, reset      - system clock, async active-high reset
//   rin / rout      - serial receive / transmit lines (idle high)
//   din, send       - transmit byte and level request; txbusy while sending
//   dout, ready     - received byte, one-clk valid pulse
//   samp_clk, rx_bit_clk, tx_bit_clk - timing ticks
//   ferr            - stop-bit error pulse (only with UART_FRAMING_CHECK_EN)
// Optional feature macro: UART_FRAMING_CHECK_EN.
module uart
  import uart_pkg::*;
#(
  parameter int Width = 16,
  parameter int Incr  = 1208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rin,
  output logic       rout,
  input  logic [7:0] din,
  input  logic       send,
  output logic       txbusy,
  output logic [7:0] dout,
  output logic       ready,
  output logic       samp_clk,
  output logic       rx_bit_clk,
  output logic       tx_bit_clk
`ifdef UART_FRAMING_CHECK_EN
  , output logic     ferr
`endif
);
  uart_baud #(.Width(Width), .Incr(Incr)) u_baud (
    .clk(clk), .reset(reset), .samp_clk(samp_clk), .tx_bit_clk(tx_bit_clk)
  );

  // ---------------- transmitter ----------------
  logic                  rout_q, rout_d, txbusy_q, txbusy_d;
  logic [FRAME_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [3:0]            tx_cnt_q, tx_cnt_d;

  always_comb begin
    rout_d     = rout_q;
    txbusy_d   = txbusy_q;
    tx_shift_d = tx_shift_q;
    tx_cnt_d   = tx_cnt_q;
    if (send && !txbusy_q) begin
      txbusy_d   = 1'b1;
      tx_shift_d = {1'b1, din, 1'b0};
      tx_cnt_d   = '0;
    end else if (txbusy_q && tx_bit_clk) begin
      // the tick after the stop bit has been on the line for a full bit
      if (tx_cnt_q == 4'(FRAME_BITS)) begin
        txbusy_d = 1'b0;
      end else begin
        rout_d     = tx_shift_q[0];
        tx_shift_d = {1'b1, tx_shift_q[FRAME_BITS-1:1]};
        tx_cnt_d   = tx_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rout_q     <= 1'b1;
      txbusy_q   <= 1'b0;
      tx_shift_q <= '1;
      tx_cnt_q   <= '0;
    end else begin
      rout_q     <= rout_d;
      txbusy_q   <= txbusy_d;
      tx_shift_q <= tx_shift_d;
      tx_cnt_q   <= tx_cnt_d;
    end
  end

  assign rout   = rout_q;
  assign txbusy = txbusy_q;

  // ---------------- receiver ----------------
  logic       sync1_q, sync2_q, rx_prev_q, rx_prev_d;
  rx_state_e  rx_state_q, rx_state_d;
  logic [2:0] rx_cnt_q, rx_cnt_d, rx_nbit_q, rx_nbit_d;
  logic [7:0] rx_shift_q, rx_shift_d, dout_q, dout_d;
  logic       ready_q, ready_d, rx_bit_q, rx_bit_d, ferr_q, ferr_d;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_nbit_d  = rx_nbit_q;
    rx_shift_d = rx_shift_q;
    dout_d     = dout_q;
    ready_d    = 1'b0;
    rx_bit_d   = 1'b0;
    ferr_d     = 1'b0;
    // line level as seen at the previous tick, for start-edge detection
    rx_prev_d  = samp_clk ? sync2_q : rx_prev_q;
    if (samp_clk) begin
      unique case (rx_state_q)
        RX_IDLE: if (rx_prev_q && !sync2_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
        RX_START: if (rx_cnt_q == 3'(START_SAMPLE-1)) begin
          rx_bit_d   = 1'b1;
          rx_cnt_d   = '0;
          rx_nbit_d  = '0;
          rx_state_d = sync2_q ? RX_IDLE : RX_DATA;  // high here = glitch
        end else rx_cnt_d = rx_cnt_q + 3'd1;
        RX_DATA: if (rx_cnt_q == 3'(OVERSAMPLE-1)) begin
          rx_bit_d   = 1'b1;
          rx_cnt_d   = '0;
          rx_shift_d = {sync2_q, rx_shift_q[7:1]};
          if (rx_nbit_q == 3'(DATA_BITS-1)) rx_state_d = RX_STOP;
          else rx_nbit_d = rx_nbit_q + 3'd1;
        end else rx_cnt_d = rx_cnt_q + 3'd1;
        RX_STOP: if (rx_cnt_q == 3'(OVERSAMPLE-1)) begin
          rx_bit_d   = 1'b1;
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
`ifdef UART_FRAMING_CHECK_EN
          if (sync2_q) begin
            dout_d  = rx_shift_q;
            ready_d = 1'b1;
          end else ferr_d = 1'b1;
`else
          dout_d  = rx_shift_q;
          ready_d = 1'b1;
`endif
        end else rx_cnt_d = rx_cnt_q + 3'd1;
        default: rx_state_d = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_nbit_q  <= '0;
      rx_shift_q <= '0;
      dout_q     <= '0;
      ready_q    <= 1'b0;
      rx_bit_q   <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      sync1_q    <= rin;
      sync2_q    <= sync1_q;
      rx_prev_q  <= rx_prev_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_nbit_q  <= rx_nbit_d;
      rx_shift_q <= rx_shift_d;
      dout_q     <= dout_d;
      ready_q    <= ready_d;
      rx_bit_q   <= rx_bit_d;
      ferr_q     <= ferr_d;
    end
  end

  assign dout       = dout_q;
  assign ready      = ready_q;
  assign rx_bit_clk = rx_bit_q;
`ifdef UART_FRAMING_CHECK_EN
  assign ferr = ferr_q;
`else
  logic unused_ferr;
  assign unused_ferr = ferr_q;
`endif
endmodule

// File: tb/tb_uart.sv
// Loopback bench for uart (Width=2, Incr=1: 4 clks per tick, 32 clks per bit).
module tb_uart;
  logic clk = 1'b0, reset, rin, rout, send, txbusy, ready;
  logic samp_clk, rx_bit_clk, tx_bit_clk, rin_force;
  logic [7:0] din, dout;
`ifdef UART_FRAMING_CHECK_EN
  logic ferr;
`endif
  int checks = 0, errors = 0, ready_cnt = 0, rxbit_cnt = 0, ferr_cnt = 0;
  logic [7:0] tx_q[$], rx_q[$];
  logic ready_d1 = 1'b0;

  always #5 clk = ~clk;
  assign rin = rin_force ? 1'b0 : rout;

  uart #(.Width(2), .Incr(1)) dut (
    .clk(clk), .reset(reset), .rin(rin), .rout(rout), .din(din), .send(send),
    .txbusy(txbusy), .dout(dout), .ready(ready), .samp_clk(samp_clk),
    .rx_bit_clk(rx_bit_clk), .tx_bit_clk(tx_bit_clk)
`ifdef UART_FRAMING_CHECK_EN
    , .ferr(ferr)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++; errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // receive-side monitor: every ready must match the oldest byte sent
  always @(negedge clk) begin
    if (!reset) begin
      if (ready) begin
        ready_cnt++;
        chk("ready_one_clk", ready_d1, 0);
        if (rx_q.size() == 0) fail_now("unexpected_ready");
        else chk("rx_byte", dout, rx_q.pop_front());
      end
      if (rx_bit_clk) rxbit_cnt++;
`ifdef UART_FRAMING_CHECK_EN
      if (ferr) ferr_cnt++;
`endif
    end
    ready_d1 <= ready;
  end

  // line monitor: decode rout at mid-bit points and compare with 8N1 framing
  initial begin : txmon
    logic prev, aborted;
    logic [9:0] got;
    logic [7:0] e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!reset && prev && !rout) begin
        aborted = 1'b0;
        repeat (16) @(negedge clk);
        got[0] = rout; if (reset) aborted = 1'b1;
        for (int i = 1; i < 10; i++) begin
          repeat (32) @(negedge clk);
          got[i] = rout;
          if (reset) aborted = 1'b1;
        end
        if (!aborted) begin
          if (tx_q.size() == 0) fail_now("unexpected_frame");
          else begin
            e = tx_q.pop_front();
            chk("tx_frame", got, {1'b1, e, 1'b0});
          end
        end
      end
      prev = rout;
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic wait_tbc();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (tx_bit_clk) return;
    end
    fail_now("tx_bit_clk_timeout");
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (txbusy && n < 2000) begin @(posedge clk); #1; n++; end
    if (txbusy) fail_now("txbusy_stuck");
    din = b; send = 1'b1;
    @(posedge clk); #1;
    chk("txbusy_rise", txbusy, 1);
    tx_q.push_back(b); rx_q.push_back(b);
    send = 1'b0; din = 8'($urandom);  // must not disturb the frame in flight
  endtask

  task automatic drain();
    for (int i = 0; i < 4000; i++) begin
      if (rx_q.size() == 0 && tx_q.size() == 0 && !txbusy) return;
      @(posedge clk); #1;
    end
    fail_now("drain_timeout");
  endtask

  initial begin : main
    int n, r0;
    logic [7:0] d0;
    reset = 1'b1; send = 1'b0; din = 8'h00; rin_force = 1'b0;
    repeat (8) @(posedge clk); #1;
    chk("rst_rout", rout, 1);
    chk("rst_txbusy", txbusy, 0);
    chk("rst_ready", ready, 0);
    chk("rst_dout", dout, 0);
    chk("rst_samp", samp_clk, 0);
    chk("rst_rxbit", rx_bit_clk, 0);
    chk("rst_txbit", tx_bit_clk, 0);
    reset = 1'b0;
    wait_tbc(); wait_tbc();
    chk("idle_txbusy", txbusy, 0);
    chk("idle_ready", ready, 0);
    chk("idle_rout", rout, 1);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!tx_bit_clk && n < 200);
    chk("tx_bit_period", n, 32);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!samp_clk && n < 20);
    do begin @(posedge clk); #1; n++; end while (!samp_clk && n < 40);
    chk("samp_period_ok", (n >= 4) ? 32'd1 : 32'd0, 1);

    // two frames back to back
    r0 = rxbit_cnt;
    send_byte(8'hA9);
    send_byte(8'h99);
    drain();
    chk("rx_bit_pulses", rxbit_cnt - r0, 20);

    // long idle then two more
    repeat (500) @(posedge clk); #1;
    send_byte(8'hB1);
    send_byte(8'hEA);
    drain();

    // send held high across two frames
    din = 8'h55; send = 1'b1;
    @(posedge clk); #1;
    chk("held_first", txbusy, 1);
    tx_q.push_back(8'h55); rx_q.push_back(8'h55);
    n = 0;
    while (txbusy && n < 2000) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    chk("held_second", txbusy, 1);
    tx_q.push_back(8'h55); rx_q.push_back(8'h55);
    send = 1'b0;
    drain();

    // random bytes with random gaps
    for (int k = 0; k < 10; k++) begin
      repeat ($urandom_range(0, 200)) @(posedge clk);
      #1;
      send_byte(8'($urandom));
    end
    drain();

    // short low glitch: two ticks only
    r0 = ready_cnt;
    rin_force = 1'b1;
    repeat (8) @(posedge clk); #1;
    rin_force = 1'b0;
    repeat (400) @(posedge clk); #1;
    chk("glitch_no_ready", ready_cnt - r0, 0);

    // line held low for a whole frame: stop bit reads 0
    r0 = ready_cnt; d0 = dout;
`ifndef UART_FRAMING_CHECK_EN
    rx_q.push_back(8'h00);
`endif
    rin_force = 1'b1;
    repeat (384) @(posedge clk); #1;
    rin_force = 1'b0;
    repeat (64) @(posedge clk); #1;
`ifdef UART_FRAMING_CHECK_EN
    chk("ferr_pulse", ferr_cnt, 1);
    chk("ferr_no_ready", ready_cnt - r0, 0);
    chk("ferr_dout_hold", dout, d0);
`else
    drain();
    chk("break_ready", ready_cnt - r0, 1);
    chk("break_dout", dout, 0);
`endif

    // reset in the middle of a frame aborts both directions
    send_byte(8'h3C);
    repeat (150) @(posedge clk); #1;
    tx_q.delete(); rx_q.delete();
    reset = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("midrst_rout", rout, 1);
    chk("midrst_txbusy", txbusy, 0);
    chk("midrst_dout", dout, 0);
    repeat (38) @(posedge clk); #1;
    reset = 1'b0;
    r0 = ready_cnt;
    repeat (500) @(posedge clk); #1;
    chk("midrst_no_ready", ready_cnt - r0, 0);
    send_byte(8'hC3);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
